// File: rtl/alu_pkg.sv
// Shared types and widths for the ALU request arbiter and its ALU.
package alu_pkg;

  localparam int ALU_IN_W  = 4;
  localparam int ALU_OUT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    FN_ADD,
    FN_OR,
    FN_AND,
    FN_CAT
  } alu_fn_t;

endpackage

// File: rtl/ArithmeticLogicUnit.sv
// Four-function 4-bit ALU with an 8-bit result, purely combinational.
module ArithmeticLogicUnit
  import alu_pkg::*;
(
  input  logic [ALU_IN_W-1:0]  A,
  input  logic [ALU_IN_W-1:0]  B,
  input  logic [1:0]           Function,
  output logic [ALU_OUT_W-1:0] ALUout
);

  // Decode the function code and produce the zero-extended result.
  always_comb begin
    ALUout = '0;
    case (alu_fn_t'(Function))
      FN_ADD:  ALUout = ALU_OUT_W'(A) + ALU_OUT_W'(B);
      FN_OR:   ALUout = {{(ALU_OUT_W-1){1'b0}}, |{A, B}};
      FN_AND:  ALUout = {{(ALU_OUT_W-1){1'b0}}, &{A, B}};
      FN_CAT:  ALUout = {A, B};
      default: ALUout = '0;
    endcase
  end

endmodule

// File: rtl/alu_request_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters.
// A grant in IDLE latches the winner's operands, EXEC registers the ALU
// result, RESP holds it until the consumer takes it.
module alu_request_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1,
  parameter int CNT_W   = 16
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  input  logic [NUM_REQ-1:0]            ReqValid,
  input  logic [ALU_IN_W*NUM_REQ-1:0]   ReqA,
  input  logic [ALU_IN_W*NUM_REQ-1:0]   ReqB,
  input  logic [2*NUM_REQ-1:0]          ReqFunction,
  output logic [NUM_REQ-1:0]            ReqReady,
  output logic                          RespValid,
  input  logic                          RespReady,
  output logic [ID_W-1:0]               RespId,
  output logic [ALU_OUT_W-1:0]          RespData,
  output logic [CNT_W-1:0]              OpCount
);

  state_t                 state_reg, state_next;
  logic [ID_W-1:0]        last_reg;
  logic [ALU_IN_W-1:0]    op_a_reg, op_b_reg;
  logic [1:0]             op_fn_reg;
  logic [ID_W-1:0]        op_id_reg;
  logic                   resp_valid_reg;
  logic [ID_W-1:0]        resp_id_reg;
  logic [ALU_OUT_W-1:0]   resp_data_reg;
  logic [CNT_W-1:0]       op_count_reg;

  logic                   grant_valid;
  logic [ID_W-1:0]        grant_id;
  logic [ALU_IN_W-1:0]    sel_a, sel_b;
  logic [1:0]             sel_fn;
  int                     idx;
  logic [ALU_OUT_W-1:0]   alu_out;

  // Round-robin search: first valid requester after the last winner.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    sel_a       = '0;
    sel_b       = '0;
    sel_fn      = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_reg) + k) % NUM_REQ;
      if (!grant_valid && ReqValid[idx]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx);
        sel_a       = ReqA[ALU_IN_W*idx +: ALU_IN_W];
        sel_b       = ReqB[ALU_IN_W*idx +: ALU_IN_W];
        sel_fn      = ReqFunction[2*idx +: 2];
      end
    end
  end

  // Acceptance is only offered while idle, one-hot on the winner.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign ReqReady[gi] = (state_reg == IDLE) && grant_valid &&
                            (grant_id == ID_W'(gi));
    end
  endgenerate

  // The ALU only ever sees the latched operands.
  ArithmeticLogicUnit u_alu (
    .A        (op_a_reg),
    .B        (op_b_reg),
    .Function (op_fn_reg),
    .ALUout   (alu_out)
  );

  // FSM state register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic: IDLE -> EXEC on grant, EXEC -> RESP, RESP -> IDLE on handshake.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (RespReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, result registration and completion counting.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      last_reg       <= ID_W'(NUM_REQ - 1);
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      op_fn_reg      <= '0;
      op_id_reg      <= '0;
      resp_valid_reg <= 1'b0;
      resp_id_reg    <= '0;
      resp_data_reg  <= '0;
      op_count_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            op_a_reg  <= sel_a;
            op_b_reg  <= sel_b;
            op_fn_reg <= sel_fn;
            op_id_reg <= grant_id;
            last_reg  <= grant_id;
          end
        end
        EXEC: begin
          resp_data_reg  <= alu_out;
          resp_id_reg    <= op_id_reg;
          resp_valid_reg <= 1'b1;
        end
        RESP: begin
          if (RespReady) begin
            resp_valid_reg <= 1'b0;
            op_count_reg   <= op_count_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign RespValid = resp_valid_reg;
  assign RespId    = resp_id_reg;
  assign RespData  = resp_data_reg;
  assign OpCount   = op_count_reg;

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Directed bench for alu_request_arbiter (2 requesters, 4-bit counter).
module tb_alu_request_arbiter;

  logic       Clock;
  logic       Resetn;
  logic [1:0] ReqValid;
  logic [7:0] ReqA;
  logic [7:0] ReqB;
  logic [3:0] ReqFunction;
  logic [1:0] ReqReady;
  logic       RespValid;
  logic       RespReady;
  logic [0:0] RespId;
  logic [7:0] RespData;
  logic [3:0] OpCount;

  int errors = 0;
  int checks = 0;

  alu_request_arbiter #(.NUM_REQ(2), .ID_W(1), .CNT_W(4)) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .ReqValid    (ReqValid),
    .ReqA        (ReqA),
    .ReqB        (ReqB),
    .ReqFunction (ReqFunction),
    .ReqReady    (ReqReady),
    .RespValid   (RespValid),
    .RespReady   (RespReady),
    .RespId      (RespId),
    .RespData    (RespData),
    .OpCount     (OpCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int req, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] fn);
    ReqA[4*req +: 4]        = a;
    ReqB[4*req +: 4]        = b;
    ReqFunction[2*req +: 2] = fn;
  endtask

  // One full operation from one requester with RespReady held high.
  // Called at posedge+1 with the arbiter idle; returns at posedge+1, idle again.
  task automatic run_op(input int req, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] fn, input logic [7:0] exp, input string tag);
    int n;
    n = 0;
    set_req(req, a, b, fn);
    ReqValid[req] = 1'b1;
    #1;
    while (!ReqReady[req] && n < 20) begin
      @(posedge Clock); #1;
      n++;
    end
    check({tag, "_grant"}, 32'(ReqReady), 32'(1) << req);
    @(posedge Clock); #1;
    ReqValid[req] = 1'b0;
    @(posedge Clock); #1;
    check({tag, "_valid"}, 32'(RespValid), 32'd1);
    check({tag, "_id"}, 32'(RespId), 32'(req));
    check({tag, "_data"}, 32'(RespData), 32'(exp));
    @(posedge Clock); #1;
    $display("op %s: req=%0d a=%0h b=%0h fn=%0d data=%0h count=%0d", tag, req, a, b, fn, RespData, OpCount);
  endtask

  initial begin
    Resetn      = 1'b0;
    ReqValid    = '0;
    ReqA        = '0;
    ReqB        = '0;
    ReqFunction = '0;
    RespReady   = 1'b1;

    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    check("rst_ready", 32'(ReqReady), 32'd0);
    check("rst_valid", 32'(RespValid), 32'd0);
    check("rst_data", 32'(RespData), 32'd0);
    check("rst_id", 32'(RespId), 32'd0);
    check("rst_count", 32'(OpCount), 32'd0);
    #1 Resetn = 1'b1;
    @(posedge Clock); #1;

    // Single add with cycle-accurate latency checks
    set_req(0, 4'd9, 4'd8, 2'd0);
    ReqValid[0] = 1'b1;
    #1;
    check("add_ready_same_cycle", 32'(ReqReady), 32'd1);
    @(posedge Clock); #1;
    ReqValid[0] = 1'b0;
    check("add_exec_ready", 32'(ReqReady), 32'd0);
    check("add_exec_valid", 32'(RespValid), 32'd0);
    @(posedge Clock); #1;
    check("add_valid", 32'(RespValid), 32'd1);
    check("add_data", 32'(RespData), 32'h11);
    check("add_id", 32'(RespId), 32'd0);
    check("add_count_before", 32'(OpCount), 32'd0);
    @(posedge Clock); #1;
    check("add_count_after", 32'(OpCount), 32'd1);
    check("add_valid_clear", 32'(RespValid), 32'd0);
    $display("op add: data=%0h count=%0d", RespData, OpCount);

    // Function encodings
    run_op(0, 4'hA, 4'h5, 2'd3, 8'hA5, "fn_cat");
    run_op(0, 4'h0, 4'h0, 2'd1, 8'h00, "fn_or_zero");
    run_op(0, 4'hF, 4'hF, 2'd2, 8'h01, "fn_and_ones");
    run_op(0, 4'hF, 4'hE, 2'd2, 8'h00, "fn_and_miss");
    check("fn_count", 32'(OpCount), 32'd5);

    // Reset during EXEC discards the in-flight result
    set_req(0, 4'd1, 4'd2, 2'd0);
    ReqValid[0] = 1'b1;
    #1;
    check("mid_grant", 32'(ReqReady), 32'd1);
    @(posedge Clock); #1;
    ReqValid[0] = 1'b0;
    Resetn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(RespValid), 32'd0);
    check("mid_rst_count", 32'(OpCount), 32'd0);
    check("mid_rst_data", 32'(RespData), 32'd0);
    @(posedge Clock); #2;
    Resetn = 1'b1;
    $display("op mid_reset: valid=%0d count=%0d", RespValid, OpCount);

    // Fairness from reset: both requesters held, order 0,1,0,1,0,1
    set_req(0, 4'd1, 4'd1, 2'd0);
    set_req(1, 4'd2, 4'd3, 2'd0);
    ReqValid = 2'b11;
    #1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("fair%0d_grant", i), 32'(ReqReady), (i % 2 == 0) ? 32'd1 : 32'd2);
      @(posedge Clock); #1;
      check($sformatf("fair%0d_exec_ready", i), 32'(ReqReady), 32'd0);
      @(posedge Clock); #1;
      check($sformatf("fair%0d_id", i), 32'(RespId), 32'(i % 2));
      check($sformatf("fair%0d_data", i), 32'(RespData), (i % 2 == 0) ? 32'd2 : 32'd5);
      check($sformatf("fair%0d_resp_ready", i), 32'(ReqReady), 32'd0);
      @(posedge Clock); #1;
      $display("op fair%0d: id=%0d data=%0h count=%0d", i, RespId, RespData, OpCount);
    end
    ReqValid = 2'b00;
    check("fair_count", 32'(OpCount), 32'd6);

    // Backpressure with requester 1 pending
    RespReady = 1'b0;
    set_req(0, 4'd3, 4'd4, 2'd3);
    set_req(1, 4'd7, 4'd7, 2'd0);
    ReqValid = 2'b01;
    #1;
    check("bp_grant", 32'(ReqReady), 32'd1);
    @(posedge Clock); #1;
    ReqValid = 2'b10;
    @(posedge Clock); #1;
    check("bp_valid", 32'(RespValid), 32'd1);
    check("bp_data", 32'(RespData), 32'h34);
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      check($sformatf("bp%0d_valid", i), 32'(RespValid), 32'd1);
      check($sformatf("bp%0d_data", i), 32'(RespData), 32'h34);
      check($sformatf("bp%0d_id", i), 32'(RespId), 32'd0);
      check($sformatf("bp%0d_ready", i), 32'(ReqReady), 32'd0);
      check($sformatf("bp%0d_count", i), 32'(OpCount), 32'd6);
    end
    RespReady = 1'b1;
    @(posedge Clock); #1;
    check("bp_count_after", 32'(OpCount), 32'd7);
    check("bp_valid_clear", 32'(RespValid), 32'd0);
    check("bp_next_grant", 32'(ReqReady), 32'd2);
    $display("op backpressure: data=34 count=%0d", OpCount);
    @(posedge Clock); #1;
    ReqValid = 2'b00;
    @(posedge Clock); #1;
    check("bp1_id", 32'(RespId), 32'd1);
    check("bp1_data", 32'(RespData), 32'h0E);
    @(posedge Clock); #1;
    check("bp1_count", 32'(OpCount), 32'd8);
    $display("op pending_req1: data=%0h count=%0d", RespData, OpCount);

    // Counter wrap: 9 more operations brings the total to 17
    for (int i = 0; i < 9; i++) begin
      run_op(i % 2, 4'(i), 4'd1, 2'd0, 8'(i + 1), $sformatf("wrap%0d", i));
      if (i == 7) check("wrap_at_16", 32'(OpCount), 32'd0);
    end
    check("wrap_at_17", 32'(OpCount), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_request_arbiter.md
# alu_request_arbiter

Shares a single 4-bit ArithmeticLogicUnit between `NUM_REQ` requesters using round-robin arbitration and a valid/ready handshake on both the request and response sides. Each accepted request is registered, executed on the ALU one cycle later, and its 8-bit result is returned tagged with the requester index. The block sits between the lab control logic (switch/key sequencers, test drivers) and the ALU datapath, and owns the only ALU instance.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..4.
- `ID_W`, default 1: width of requester index; equals `$clog2(NUM_REQ)`, minimum 1.
- `CNT_W`, default 16: width of the completed-operation counter.

- `Clock`  in  1  sole clock; all state changes on the rising edge.
- `Resetn`  in  1  reset, asynchronous and active-low.
- `ReqValid`  in  NUM_REQ  bit i set: requester i presents an operation.
- `ReqA`  in  4*NUM_REQ  operand A of requester i in bits [4i+3:4i].
- `ReqB`  in  4*NUM_REQ  operand B, same packing.
- `ReqFunction`  in  2*NUM_REQ  ALU function of requester i in bits [2i+1:2i].
- `ReqReady`  out  NUM_REQ  one-hot or zero; bit i set means requester i is accepted this cycle.
- `RespValid`  out  1  result available.
- `RespReady`  in  1  consumer takes the result.
- `RespId`  out  ID_W  index of the requester that issued the result.
- `RespData`  out  8  ALU result.
- `OpCount`  out  CNT_W  number of completed response handshakes; wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `ReqValid` bit is set, grant the first set bit searching from `Last+1` upward modulo NUM_REQ.
  - `ReqReady[grant]` = 1 combinationally in that same cycle.
  - Latch the winner's A, B, Function and ID into operand registers, set `Last` = grant, and go to EXEC.
  - With no valid request, stay in IDLE and hold `ReqReady` = 0.
- EXEC: the ALU sees only the latched operands. Register its output into `RespData`, copy the latched ID into `RespId`, set `RespValid` = 1, and go to RESP. `ReqReady` = 0.
- RESP: hold `RespValid`, `RespData` and `RespId` stable until `RespReady` = 1. On the handshake edge, clear `RespValid`, increment `OpCount`, and return to IDLE. `ReqReady` = 0.
- Function encoding is the ALU's:
  - 0: A+B, zero-extended to 8 bits (max 8'd30).
  - 1: 8'd1 if any bit of {A,B} is set, else 0.
  - 2: 8'd1 if all 8 bits of {A,B} are set, else 0.
  - 3: {A,B}.
- Requests are never dropped. A requester keeps `ReqValid` high, with stable operands, until it sees `ReqReady`. Deasserting `ReqValid` before the grant is legal and simply withdraws the request.
- Reset values: state IDLE, `Last` = NUM_REQ-1 (requester 0 has first priority), `ReqReady` = 0, `RespValid` = 0, `RespData` = 0, `RespId` = 0, `OpCount` = 0, operand registers 0.
- Reset asserted mid-operation aborts immediately. An in-flight result is discarded and `OpCount` is not incremented.

## Timing
- The request accepted on edge N appears as `RespValid` after edge N+1 (2-cycle latency).
- Maximum throughput is one operation per 3 cycles when `RespReady` is held high.
- A RESP→IDLE transition and a new grant cannot happen in the same cycle. `ReqReady` is asserted only in IDLE, so the earliest next grant is the cycle after the response handshake.
- `ReqReady` depends combinationally on `ReqValid` and registered state only. `RespValid`, `RespData` and `RespId` are driven purely from registers.
- `Last` updates only on a grant, so fairness is per granted operation, not per cycle.

## Structure
- Shared package `alu_pkg`:
  - typedef enum for FSM states {IDLE, EXEC, RESP}.
  - typedef enum logic [1:0] for ALU functions {FN_ADD, FN_OR, FN_AND, FN_CAT}.
  - constants `ALU_IN_W` = 4 and `ALU_OUT_W` = 8.
- Sub-modules:
  - One instance of the existing ArithmeticLogicUnit, fed from the operand registers.
  - No other sub-module. The round-robin priority search stays inline as a combinational loop.

## Test plan
- Single add: requester 0 sends A=9, B=8, Fn=0 with `RespReady` = 1 → `ReqReady[0]` is set the same cycle; two edges later `RespData` = 8'h11, `RespId` = 0; `OpCount` = 1 after the handshake.
- Functions: A=4'hA, B=4'h5, Fn=3 → 8'hA5. A=0, B=0, Fn=1 → 8'h00. A=F, B=F, Fn=2 → 8'h01. A=F, B=E, Fn=2 → 8'h00.
- Fairness: both requesters hold `ReqValid` continuously for 6 operations from reset → grant order 0,1,0,1,0,1, with `RespId` matching that order.
- Backpressure: `RespReady` = 0 for 5 cycles after `RespValid` rises → `RespData` and `RespId` stay stable, `ReqReady` stays 0 despite a pending request from requester 1, and `OpCount` is unchanged until the handshake.
- Reset mid-operation: drop `Resetn` while in EXEC → `RespValid` = 0, `OpCount` = 0, and after release requester 0 wins the first grant.
- Counter wrap: with CNT_W=4, complete 17 operations → `OpCount` = 1.
